// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory controller. The pipeline top
// imports this package so its stall/resume decode compares against DMEM_DONE
// rather than a bare literal.
//
// Contents:
//   dmem_status_t      - 2-bit status bus encoding seen by the pipeline
//   dmem_state_t       - controller FSM state (encoded identically to status)
//   DMEM_BASE_DEFAULT  - default byte address of word 0
//   state_to_status()  - maps an FSM state onto the status encoding
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'b00,
        DMEM_BUSY = 2'b01,
        DMEM_DONE = 2'b10,
        DMEM_ERR  = 2'b11
    } dmem_status_t;

    // State encodings match the status encodings so the status bus can be
    // driven straight from the state register with no decode logic.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } dmem_state_t;

    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

    function automatic dmem_status_t state_to_status(input dmem_state_t s);
        dmem_status_t r;
        case (s)
            ST_IDLE: r = DMEM_IDLE;
            ST_BUSY: r = DMEM_BUSY;
            ST_DONE: r = DMEM_DONE;
            default: r = DMEM_ERR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Single-port synchronous RAM, DEPTH x 32 bits, with per-byte write enables
// and a registered read port. The read register only updates when rd_en is
// high, so it doubles as the controller's held load-result register.
// Array contents are never cleared; only the read register is reset.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset (read register only)
//   wr_en   in   write strobe for this edge
//   rd_en   in   capture mem[idx] into r_data on this edge
//   idx     in   word index [AW-1:0]
//   w_data  in   write data [31:0]
//   be      in   byte write mask [3:0]; bit b enables w_data[8b+7:8b]
//   r_data  out  registered read data [31:0]
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   w_data,
    input  logic [3:0]    be,
    output logic [31:0]   r_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en && be[b]) begin
                mem[idx][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 32'h0;
        end else if (rd_en) begin
            r_data <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Multi-cycle data-memory controller for the MIPS32 Memory stage. Accepts one
// word load/store at a time, spends LATENCY cycles in BUSY, then reports DONE
// for one cycle (the pipeline's resume condition). Illegal requests (misaligned
// or outside [BASE_ADDR, BASE_ADDR + DEPTH*4)) report ERR for one cycle with no
// side effects.
//
// Optional feature: define DMEM_BYTE_EN to add the `be` port and make stores
// honour per-byte enables. Without it every store writes the full word.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two)
//   LATENCY    BUSY cycles per access (>= 1)
//   BASE_ADDR  byte address of word 0 (aligned to DEPTH*4)
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   req     in   level-sensitive access request, sampled only in IDLE
//   we      in   1 = store, 0 = load
//   addr    in   byte address [31:0]
//   w_data  in   store data [31:0]
//   be      in   byte enables [3:0] (DMEM_BYTE_EN builds only)
//   r_data  out  load result [31:0], held until the next load completes
//   status  out  00 IDLE, 01 BUSY, 10 DONE, 11 ERR (the state register itself)
//
// Handshake: the controller samples req/we/addr/w_data(/be) only on an edge
// that ends an IDLE cycle; everything else is ignored until the next IDLE.
// A req still high in the IDLE cycle after DONE/ERR is a fresh request.
// -----------------------------------------------------------------------------
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] w_data,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]  be,
`endif
    output logic [31:0] r_data,
    output logic [1:0]  status
);

    localparam int AW = $clog2(DEPTH);
    // LATENCY-1 must fit; a 1-bit counter covers LATENCY of 1 or 2.
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    dmem_state_t   state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_eff;

    logic [31:0]   offset;
    logic          legal;
    logic          finish;
    logic          arr_wr_en;
    logic          arr_rd_en;

    // Subtracting the base makes addresses below BASE_ADDR wrap to huge
    // offsets, so a single "high bits are zero" test covers both bounds.
    assign offset = addr - BASE_ADDR;
    assign legal  = (addr[1:0] == 2'b00) && (offset[31:AW+2] == '0);

`ifdef DMEM_BYTE_EN
    logic [3:0] be_q;
    assign be_eff = be_q;
`else
    assign be_eff = 4'hF;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
`ifdef DMEM_BYTE_EN
            be_q    <= 4'h0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (legal) begin
                            we_q    <= we;
                            idx_q   <= offset[AW+1:2];
                            wdata_q <= w_data;
`ifdef DMEM_BYTE_EN
                            be_q    <= be;
`endif
                            cnt     <= CNT_LOAD;
                            state   <= ST_BUSY;
                        end else begin
                            state   <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The BUSY->DONE edge performs the access. Gating with rst means a reset
    // landing on that same edge suppresses the store (and the load capture,
    // which the array's own reset would override anyway).
    assign finish    = (state == ST_BUSY) && (cnt == '0) && !rst;
    assign arr_wr_en = finish && we_q;
    assign arr_rd_en = finish && !we_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (arr_wr_en),
        .rd_en  (arr_rd_en),
        .idx    (idx_q),
        .w_data (wdata_q),
        .be     (be_eff),
        .r_data (r_data)
    );

    assign status = state_to_status(state);

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Directed bench for dmem_ctrl with a reference memory model. Each access
// pushes the expected per-cycle {status, r_data} into exp_q; run_checks pops
// one entry per cycle and compares. Honours DMEM_BYTE_EN like the DUT.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h1001_0000;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] w_data;
`ifdef DMEM_BYTE_EN
    logic [3:0]  be;
`endif
    logic [31:0] r_data;
    logic [1:0]  status;

    dmem_ctrl #(
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .BASE_ADDR (BASE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .w_data (w_data),
`ifdef DMEM_BYTE_EN
        .be     (be),
`endif
        .r_data (r_data),
        .status (status)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_model [int];
    logic [31:0] rd_model;
    int          n_compared;
    int          n_failed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_compared++;
        assert (obs === exp_v) else begin
            n_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a <= BASE + 32'(DEPTH*4) - 32'd4);
    endfunction

    // Queue the expected cycle-by-cycle outcome of one access, starting with
    // the cycle after the accept edge.
    task automatic push_access(input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] bm);
        logic [3:0]  bm_eff;
        logic [31:0] word;
        int          key;
`ifdef DMEM_BYTE_EN
        bm_eff = bm;
`else
        bm_eff = 4'hF;
`endif
        if (!addr_legal(a)) begin
            exp_q.push_back('{st: DMEM_ERR,  rd: rd_model});
            exp_q.push_back('{st: DMEM_IDLE, rd: rd_model});
        end else begin
            key = int'((a - BASE) >> 2);
            for (int i = 0; i < LATENCY; i++)
                exp_q.push_back('{st: DMEM_BUSY, rd: rd_model});
            word = mem_model.exists(key) ? mem_model[key] : 32'h0;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (bm_eff[b]) word[8*b +: 8] = d[8*b +: 8];
                mem_model[key] = word;
            end else begin
                rd_model = word;
            end
            exp_q.push_back('{st: DMEM_DONE, rd: rd_model});
            exp_q.push_back('{st: DMEM_IDLE, rd: rd_model});
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] bm);
        req    = 1'b1;
        we     = w;
        addr   = a;
        w_data = d;
`ifdef DMEM_BYTE_EN
        be     = bm;
`else
        if (bm == 4'hx) req = 1'b1;
`endif
    endtask

    // Pop one expectation per cycle; req is dropped right after edge drop_edge.
    task automatic run_checks(input int drop_edge);
        exp_t e;
        int   k;
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            k++;
            if (k == drop_edge) req = 1'b0;
            e = exp_q.pop_front();
            @(negedge clk);
            check("status", 32'(status), 32'(e.st));
            check("r_data", r_data, e.rd);
        end
        req = 1'b0;
    endtask

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] bm);
        drive(w, a, d, bm);
        push_access(w, a, d, bm);
        run_checks(1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_compared = 0;
        n_failed   = 0;
        rd_model   = 32'h0;
        rst    = 1'b1;
        req    = 1'b0;
        we     = 1'b0;
        addr   = 32'h0;
        w_data = 32'h0;
`ifdef DMEM_BYTE_EN
        be     = 4'h0;
`endif

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_status", 32'(status), 32'(DMEM_IDLE));
        check("reset_r_data", r_data, 32'h0);

        // Store then load.
        access(1'b1, 32'h1001_0010, 32'hDEAD_BEEF, 4'hF);
        access(1'b0, 32'h1001_0010, 32'h0, 4'hF);

        // Illegal: misaligned, one past the end, below base; then a legal load.
        access(1'b0, 32'h1001_0002, 32'h0, 4'hF);
        access(1'b0, BASE + 32'(DEPTH*4), 32'h0, 4'hF);
        access(1'b1, BASE - 32'd4, 32'h5555_5555, 4'hF);
        access(1'b0, 32'h1001_0010, 32'h0, 4'hF);

        // Last legal word.
        access(1'b1, BASE + 32'(DEPTH*4) - 32'd4, 32'hCAFE_F00D, 4'hF);
        access(1'b0, BASE + 32'(DEPTH*4) - 32'd4, 32'h0, 4'hF);
        access(1'b0, 32'h1001_0010, 32'h0, 4'hF);

        // Reset in the first BUSY cycle aborts the store.
        drive(1'b1, 32'h1001_0010, 32'h1234_5678, 4'hF);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(status), 32'(DMEM_BUSY));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        rd_model = 32'h0;
        @(negedge clk);
        check("abort_status", 32'(status), 32'(DMEM_IDLE));
        check("abort_r_data", r_data, 32'h0);
        access(1'b0, 32'h1001_0010, 32'h0, 4'hF);

        // Held request: second access is accepted in the IDLE after DONE.
        access(1'b1, 32'h1001_0020, 32'h0BAD_F00D, 4'hF);
        access(1'b0, 32'h1001_0000, 32'h0, 4'hF);
        drive(1'b0, 32'h1001_0020, 32'h0, 4'hF);
        push_access(1'b0, 32'h1001_0020, 32'h0, 4'hF);
        push_access(1'b0, 32'h1001_0020, 32'h0, 4'hF);
        run_checks(LATENCY + 3);

        // Randomised traffic over a small window, including illegal offsets.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = BASE + 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            access(1'($urandom_range(0, 1)), a, $urandom, 4'hF);
        end

`ifdef DMEM_BYTE_EN
        access(1'b1, 32'h1001_0030, 32'h0000_0000, 4'hF);
        access(1'b1, 32'h1001_0030, 32'hAABB_CCDD, 4'b0101);
        access(1'b0, 32'h1001_0030, 32'h0, 4'h0);
        check("be_word", r_data, 32'h00BB_00DD);
        access(1'b1, 32'h1001_0030, 32'hFFFF_FFFF, 4'b0000);
        access(1'b0, 32'h1001_0030, 32'h0, 4'hF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
